data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder-side data memory for the 5-stage RISC-V core; serves load/store requests issued by the MEM stage.
- Uses a valid/ready request channel and a valid/ready response channel, with a configurable number of wait states.
- Decodes Func3 (LB/LH/LW/LBU/LHU/SB/SH/SW) into byte lanes and sign/zero extension, and flags misaligned, illegal or out-of-range accesses.
- Allows the core's stall logic to be exercised against a memory that is not single-cycle.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words stored; byte address range is 0 .. 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 2: idle cycles inserted between request acceptance and the array access; 0 is legal.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Req_Valid  input  1  core presents a request.
- Req_Ready  output  1  responder can accept a request; high only in IDLE.
- Req_Write  input  1  1 = store, 0 = load.
- Req_Func3  input  3  RISC-V funct3 of the load/store.
- Req_Addr  input  32  byte address.
- Req_Wdata  input  32  store data, taken from the low bits per Func3.
- Rsp_Valid  output  1  response available.
- Rsp_Ready  input  1  core accepts the response.
- Rsp_Rdata  output  32  extended load data; 0 for stores and errors.
- Rsp_Error  output  1  request was misaligned, illegal Func3 or out of range.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State IDLE; Req_Ready=1, Rsp_Valid=0, Rsp_Rdata=0, Rsp_Error=0; wait counter 0.
  - Array contents are not reset.
  - A request in flight is abandoned. A store that has not reached the ACCESS edge is never committed.
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - Req_Ready=1.
  - On Req_Valid=1 at an edge: latch Write, Func3, Addr and Wdata; load counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise ACCESS.
- WAIT: counter decrements each edge; go to ACCESS on the edge where the counter reaches 0 (WAIT_CYCLES cycles in WAIT in total).
- ACCESS, single cycle. At its edge:
  - Perform the read or write.
  - Register Rsp_Rdata and Rsp_Error.
  - Go to RESP.
- RESP:
  - Rsp_Valid=1, with Rdata and Error held stable, until Rsp_Ready=1 at an edge.
  - Then return to IDLE; Rsp_Valid falls and Req_Ready rises on that edge.
- Latency: acceptance at edge E0 makes Rsp_Valid high after edge E0+WAIT_CYCLES+1.
- Throughput: one outstanding request; no request is accepted while in WAIT, ACCESS or RESP.
- Rsp_Ready=1 in any state other than RESP is ignored.
- Legal Func3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Error conditions; any one of these sets Rsp_Error=1, suppresses the write and forces Rdata=0:
  - Any Func3 value not listed above.
  - Halfword access with Addr[0]=1.
  - Word access with Addr[1:0]!=0.
  - Addr >= 4*DEPTH_WORDS.
- Word index = Addr[31:2]; byte lane = Addr[1:0], little-endian.
- Stores:
  - SB writes Wdata[7:0] into lane Addr[1:0] only.
  - SH writes Wdata[15:0] into lanes {Addr[1],0} and {Addr[1],1}.
  - SW writes all 4 lanes.
  - Untouched lanes keep their old value.
- Loads:
  - LB/LH sign-extend from bit 7/15 of the selected lane(s).
  - LBU/LHU zero-extend.
  - LW returns the full word.
- Reset deasserting while Req_Valid=1: the request is accepted on the first edge after deassertion.

Test Plan:
- SW at 0x10 with Wdata=0xDEADBEEF, then LW at 0x10 (WAIT_CYCLES=2) -> each Rsp_Valid rises exactly 3 edges after acceptance; LW returns 0xDEADBEEF, Error=0.
- SB 0x80 at 0x21, then LB 0x21, LBU 0x21 and LW 0x20 (after SW 0x00000000 at 0x20) -> 0xFFFFFF80, 0x00000080, 0x00008000.
- SH 0x8001 at 0x32, then LH 0x32, LHU 0x32 and LW 0x30 (prior word 0x11112222) -> 0xFFFF8001, 0x00008001, 0x80012222.
- LW at 0x6, SH at 0x5, Func3=011, and an access at 4*DEPTH_WORDS -> each gives Rsp_Error=1 and Rdata=0; a following LW of the touched word is unchanged.
- Hold Rsp_Ready=0 for 5 cycles during RESP while Req_Valid=1 -> Rsp_Valid and Rsp_Rdata are held stable, Req_Ready=0; the second request is accepted only on the edge after the response handshake.
- SW 0x12345678 at 0x40 (prior value 0) with Reset pulsed low during WAIT -> all outputs take reset values immediately; a later LW at 0x40 returns 0x00000000.
- Repeat the first test with WAIT_CYCLES=0 -> Rsp_Valid high 1 edge after acceptance.

Source files
------------

// File: rtl/data_mem_responder.sv
// Load/store data memory responder with valid/ready request and response channels.
// Requests pass through a programmable number of wait states before the array access.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Req_Write,
  input  logic [2:0]  Req_Func3,
  input  logic [31:0] Req_Addr,
  input  logic [31:0] Req_Wdata,
  output logic        Rsp_Valid,
  input  logic        Rsp_Ready,
  output logic [31:0] Rsp_Rdata,
  output logic        Rsp_Error
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = $clog2(WAIT_CYCLES + 2);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             wr_q;
  logic [2:0]       f3_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      mem [DEPTH_WORDS];

  function automatic logic access_error(input logic wr, input logic [2:0] f3,
                                        input logic [31:0] addr);
    logic bad_f3, misalign, oor;
    bad_f3   = wr ? !(f3 inside {3'b000, 3'b001, 3'b010})
                  : !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misalign = (f3[1:0] == 2'b01 && addr[0]) ||
               (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    oor      = addr[31:2] >= 30'(DEPTH_WORDS);
    return bad_f3 || misalign || oor;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lane;
      2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  logic [IDX_W-1:0] idx;
  logic             acc_err;
  logic [31:0]      rd_word;
  logic [3:0]       be;
  logic [31:0]      wd;

  always_comb begin
    idx     = addr_q[IDX_W+1:2];
    acc_err = access_error(wr_q, f3_q, addr_q);
    rd_word = mem[idx];
    be      = store_be(f3_q, addr_q[1:0]);
    wd      = store_data(f3_q, wdata_q);
  end

  // Request capture: data path only, no reset needed
  always_ff @(posedge Clk) begin
    if (state == ST_IDLE && Req_Valid) begin
      wr_q    <= Req_Write;
      f3_q    <= Req_Func3;
      addr_q  <= Req_Addr;
      wdata_q <= Req_Wdata;
    end
  end

  // Array write happens only on the ACCESS edge; an async reset before then drops it
  always_ff @(posedge Clk) begin
    if (state == ST_ACCESS && wr_q && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      Req_Ready <= 1'b1;
      Rsp_Valid <= 1'b0;
      Rsp_Rdata <= '0;
      Rsp_Error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Req_Valid) begin
            cnt       <= CNT_W'(WAIT_CYCLES);
            Req_Ready <= 1'b0;
            state     <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt <= CNT_W'(1)) state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          Rsp_Rdata <= (acc_err || wr_q) ? 32'd0 : load_extend(f3_q, addr_q[1:0], rd_word);
          Rsp_Error <= acc_err;
          Rsp_Valid <= 1'b1;
          state     <= ST_RESP;
        end
        default: begin
          if (Rsp_Ready) begin
            Rsp_Valid <= 1'b0;
            Req_Ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: table of load/store vectors plus hand sequences
// for backpressure, reset during wait states and a zero-wait-state instance.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       req_valid, req_write, rsp_ready;
  logic [1:0][2:0]  req_func3;
  logic [1:0][31:0] req_addr, req_wdata;
  logic [1:0]       req_ready, rsp_valid, rsp_error;
  logic [1:0][31:0] rsp_rdata;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut (
    .Clk(clk), .Reset(rst_n),
    .Req_Valid(req_valid[0]), .Req_Ready(req_ready[0]), .Req_Write(req_write[0]),
    .Req_Func3(req_func3[0]), .Req_Addr(req_addr[0]), .Req_Wdata(req_wdata[0]),
    .Rsp_Valid(rsp_valid[0]), .Rsp_Ready(rsp_ready[0]), .Rsp_Rdata(rsp_rdata[0]),
    .Rsp_Error(rsp_error[0])
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .Clk(clk), .Reset(rst_n),
    .Req_Valid(req_valid[1]), .Req_Ready(req_ready[1]), .Req_Write(req_write[1]),
    .Req_Func3(req_func3[1]), .Req_Addr(req_addr[1]), .Req_Wdata(req_wdata[1]),
    .Rsp_Valid(rsp_valid[1]), .Rsp_Ready(rsp_ready[1]), .Rsp_Rdata(rsp_rdata[1]),
    .Rsp_Error(rsp_error[1])
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic err);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int d, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
    req_write[d] = wr;
    req_func3[d] = f3;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_valid[d] = 1'b1;
  endtask

  // Called #1 after the acceptance edge; counts edges until the response appears.
  task automatic wait_resp(input int d, input int lat, input logic [31:0] er,
                           input logic ee, input string nm);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(posedge clk); #1;
      if (rsp_valid[d]) begin
        got = 1'b1;
        n = i;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s timeout actual=no_rsp_valid required=rsp_valid", nm);
    end else begin
      check({nm, " latency"}, 32'(n), 32'(lat));
      check({nm, " rdata"}, rsp_rdata[d], er);
      check({nm, " error"}, 32'(rsp_error[d]), 32'(ee));
      rsp_ready[d] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[d] = 1'b0;
      check({nm, " valid_drop"}, 32'(rsp_valid[d]), 32'd0);
      check({nm, " ready_back"}, 32'(req_ready[d]), 32'd1);
    end
  endtask

  task automatic txn(input int d, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] er, input logic ee, input string nm);
    check({nm, " idle_ready"}, 32'(req_ready[d]), 32'd1);
    set_req(d, wr, f3, addr, wdata);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    check({nm, " accepted"}, 32'(req_ready[d]), 32'd0);
    wait_resp(d, (d == 0) ? 3 : 1, er, ee, nm);
  endtask

  initial begin
    req_valid = '0; req_write = '0; rsp_ready = '0;
    req_func3 = '0; req_addr = '0; req_wdata = '0;

    vecs.push_back(mk(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0));
    vecs.push_back(mk(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 3'b010, 32'h20, 32'h0, 32'h0, 0));
    vecs.push_back(mk(1, 3'b000, 32'h21, 32'h12345680, 32'h0, 0));
    vecs.push_back(mk(0, 3'b000, 32'h21, 32'h0, 32'hFFFFFF80, 0));
    vecs.push_back(mk(0, 3'b100, 32'h21, 32'h0, 32'h00000080, 0));
    vecs.push_back(mk(0, 3'b010, 32'h20, 32'h0, 32'h00008000, 0));
    vecs.push_back(mk(1, 3'b010, 32'h30, 32'h11112222, 32'h0, 0));
    vecs.push_back(mk(1, 3'b001, 32'h32, 32'hABCD8001, 32'h0, 0));
    vecs.push_back(mk(0, 3'b001, 32'h32, 32'h0, 32'hFFFF8001, 0));
    vecs.push_back(mk(0, 3'b101, 32'h32, 32'h0, 32'h00008001, 0));
    vecs.push_back(mk(0, 3'b010, 32'h30, 32'h0, 32'h80012222, 0));
    vecs.push_back(mk(1, 3'b010, 32'h4, 32'hCAFEF00D, 32'h0, 0));
    vecs.push_back(mk(1, 3'b010, 32'h0, 32'h55AA55AA, 32'h0, 0));
    vecs.push_back(mk(0, 3'b010, 32'h6, 32'h0, 32'h0, 1));
    vecs.push_back(mk(1, 3'b001, 32'h5, 32'hFFFFFFFF, 32'h0, 1));
    vecs.push_back(mk(1, 3'b011, 32'h4, 32'h11111111, 32'h0, 1));
    vecs.push_back(mk(1, 3'b100, 32'h4, 32'h22222222, 32'h0, 1));
    vecs.push_back(mk(0, 3'b011, 32'h4, 32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 3'b110, 32'h4, 32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 3'b101, 32'h7, 32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 3'b010, 32'h1000, 32'h0, 32'h0, 1));
    vecs.push_back(mk(1, 3'b010, 32'h1000, 32'h33333333, 32'h0, 1));
    vecs.push_back(mk(0, 3'b010, 32'h4, 32'h0, 32'hCAFEF00D, 0));
    vecs.push_back(mk(0, 3'b010, 32'h0, 32'h0, 32'h55AA55AA, 0));
    vecs.push_back(mk(1, 3'b010, 32'h40, 32'h0, 32'h0, 0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", 32'(req_ready[0]), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("reset rsp_rdata", rsp_rdata[0], 32'd0);
    check("reset rsp_error", 32'(rsp_error[0]), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      txn(0, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
          vecs[i].rdata, vecs[i].err, $sformatf("vec%0d", i));

    // Backpressure: response held while a second request waits
    txn(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "bp_pre");
    set_req(0, 1'b0, 3'b010, 32'h10, 32'h0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 3'b010, 32'h20, 32'h0);
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(posedge clk); #1;
        if (rsp_valid[0]) got = 1'b1;
      end
      check("bp rsp_valid_seen", 32'(got), 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp hold%0d valid", i), 32'(rsp_valid[0]), 32'd1);
      check($sformatf("bp hold%0d rdata", i), rsp_rdata[0], 32'hDEADBEEF);
      check($sformatf("bp hold%0d req_ready", i), 32'(req_ready[0]), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    check("bp handshake valid", 32'(rsp_valid[0]), 32'd0);
    check("bp handshake req_ready", 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("bp second accepted", 32'(req_ready[0]), 32'd0);
    wait_resp(0, 3, 32'h00008000, 1'b0, "bp_second");

    // Reset during WAIT abandons the store
    check("rst_wait idle_ready", 32'(req_ready[0]), 32'd1);
    set_req(0, 1'b1, 3'b010, 32'h40, 32'h12345678);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_wait req_ready", 32'(req_ready[0]), 32'd1);
    check("rst_wait rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_wait rsp_rdata", rsp_rdata[0], 32'd0);
    check("rst_wait rsp_error", 32'(rsp_error[0]), 32'd0);
    // Request already valid when reset releases
    set_req(0, 1'b0, 3'b010, 32'h40, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("rst_release accepted", 32'(req_ready[0]), 32'd0);
    wait_resp(0, 3, 32'h0, 1'b0, "rst_lw40");

    // Zero wait states
    txn(1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "w0_sw");
    txn(1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "w0_lw");
    txn(1, 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, "w0_misalign");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
